// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with PC ownership, variable-latency imem
// request/ready handshake, stall/redirect handling and the IF/ID register.
// Optional retired-fetch / bubble counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        id_redirect,
  input  logic [31:0] id_target,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_DRAIN = 2'd1,
    S_HELD  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic [XLEN-1:0] buf_q, buf_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic            valid_q, valid_d;
  logic            req_q, req_d;

  logic            redir;
  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] pc_plus4;
  logic            take_bubble;
  logic            take_load;
  logic [XLEN-1:0] load_data;

  // Redirect select: the older instruction (EX) wins over ID.
  assign redir    = ex_redirect | id_redirect;
  assign tgt      = ex_redirect ? ex_target : id_target;
  assign pc_plus4 = pc_q + PC_STEP;

  // Next-state, PC, holding buffer and IF/ID update.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    buf_d       = buf_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    take_bubble = 1'b0;
    take_load   = 1'b0;
    load_data   = '0;

    case (state_q)
      S_FETCH: begin
        if (req_q && imem_ready) begin
          if (redir) begin
            pc_d        = tgt;
            take_bubble = 1'b1;
          end else if (stall) begin
            buf_d   = imem_rdata;
            state_d = S_HELD;
          end else begin
            take_load = 1'b1;
            load_data = imem_rdata;
            pc_d      = pc_plus4;
          end
        end else if (redir) begin
          take_bubble = 1'b1;
          // An outstanding request must complete at its old address first.
          if (req_q) begin
            pend_d  = tgt;
            state_d = S_DRAIN;
          end else begin
            pc_d = tgt;
          end
        end else if (!stall) begin
          take_bubble = 1'b1;
        end
      end
      S_DRAIN: begin
        if (redir) begin
          pend_d      = tgt;
          take_bubble = 1'b1;
        end else if (!stall) begin
          take_bubble = 1'b1;
        end
        if (imem_ready) begin
          pc_d    = redir ? tgt : pend_q;
          state_d = S_FETCH;
        end
      end
      S_HELD: begin
        if (redir) begin
          pc_d        = tgt;
          take_bubble = 1'b1;
          state_d     = S_FETCH;
        end else if (!stall) begin
          take_load = 1'b1;
          load_data = buf_q;
          pc_d      = pc_plus4;
          state_d   = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase

    // Bubbles keep pc4; real loads carry the fetched word's PC+4.
    if (take_bubble) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (take_load) begin
      instr_d = load_data;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
    end

    req_d = (state_d != S_HELD);
  end

  // State and pipeline register update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      buf_q   <= '0;
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      buf_q   <= buf_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      req_q   <= req_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign op          = instr_q[31:26];
  assign func        = instr_q[5:0];

`ifdef FETCH_PERF_CNT_EN
  logic [XLEN-1:0] fetched_q, fetched_d;
  logic [XLEN-1:0] bubbles_q, bubbles_d;

  // Count every IF/ID load, split by real instruction vs bubble.
  always_comb begin
    fetched_d = fetched_q + XLEN'(take_load);
    bubbles_d = bubbles_q + XLEN'(take_bubble);
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_q <= '0;
      bubbles_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      bubbles_q <= bubbles_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_bubbles = bubbles_q;
`else
  assign perf_fetched = '0;
  assign perf_bubbles = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table plus hand sequences for fetch_stage.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        id_redirect;
  logic [31:0] id_target;
  logic        ex_redirect;
  logic [31:0] ex_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [5:0]  op;
  logic [5:0]  func;
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;

  int errors = 0;
  int checks = 0;

  fetch_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .id_redirect  (id_redirect),
    .id_target    (id_target),
    .ex_redirect  (ex_redirect),
    .ex_target    (ex_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .if_id_instr  (if_id_instr),
    .if_id_pc4    (if_id_pc4),
    .if_id_valid  (if_id_valid),
    .op           (op),
    .func         (func),
    .perf_fetched (perf_fetched),
    .perf_bubbles (perf_bubbles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        idr;
    logic [31:0] idt;
    logic        exr;
    logic [31:0] ext;
    logic        rdy;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_valid;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic st, input logic idr, input logic [31:0] idt,
                              input logic exr, input logic [31:0] ext, input logic rdy,
                              input logic [31:0] rdata, input logic e_req,
                              input logic [31:0] e_addr, input logic [31:0] e_instr,
                              input logic [31:0] e_pc4, input logic e_valid);
    vec_t v;
    v.stall = st;  v.idr = idr;  v.idt = idt;  v.exr = exr;  v.ext = ext;
    v.rdy = rdy;   v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_instr = e_instr;
    v.e_pc4 = e_pc4; v.e_valid = e_valid;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic idr, input logic [31:0] idt,
                       input logic exr, input logic [31:0] ext,
                       input logic rdy, input logic [31:0] rdata);
    stall = st; id_redirect = idr; id_target = idt;
    ex_redirect = exr; ex_target = ext; imem_ready = rdy; imem_rdata = rdata;
  endtask

  task automatic chk_state(input string tag, input logic e_req, input logic [31:0] e_addr,
                           input logic [31:0] e_instr, input logic [31:0] e_pc4,
                           input logic e_valid);
    logic [31:0] ei;
    ei = e_instr;
    chk({tag, ".req"},   32'(imem_req),    32'(e_req));
    chk({tag, ".addr"},  imem_addr,        e_addr);
    chk({tag, ".instr"}, if_id_instr,      e_instr);
    chk({tag, ".pc4"},   if_id_pc4,        e_pc4);
    chk({tag, ".valid"}, 32'(if_id_valid), 32'(e_valid));
    chk({tag, ".op"},    32'(op),          32'(ei[31:26]));
    chk({tag, ".func"},  32'(func),        32'(ei[5:0]));
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);

    // stall id idt ex ext rdy rdata | req addr instr pc4 valid
    vecs.push_back(mk(0,0,0,0,0,1,32'h1111_1111, 1,32'h0,  32'h0,          32'h0,  0)); // ready ignored, no req yet
    vecs.push_back(mk(0,0,0,0,0,1,32'hC000_0000, 1,32'h4,  32'hC000_0000,  32'h4,  1));
    vecs.push_back(mk(0,0,0,0,0,1,32'hC000_0004, 1,32'h8,  32'hC000_0004,  32'h8,  1));
    vecs.push_back(mk(0,0,0,0,0,1,32'hC000_0008, 1,32'hC,  32'hC000_0008,  32'hC,  1));
    vecs.push_back(mk(0,0,0,0,0,1,32'hC000_000C, 1,32'h10, 32'hC000_000C,  32'h10, 1));
    vecs.push_back(mk(0,1,32'h8,0,0,1,32'hC000_0010, 1,32'h8, 32'h0,       32'h10, 0)); // id redirect to 8
    vecs.push_back(mk(1,0,0,0,0,1,32'h8C22_0004, 0,32'h8,  32'h0,          32'h10, 0)); // stall -> HELD
    vecs.push_back(mk(1,0,0,0,0,0,32'h0,         0,32'h8,  32'h0,          32'h10, 0));
    vecs.push_back(mk(1,0,0,0,0,0,32'h0,         0,32'h8,  32'h0,          32'h10, 0));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0,         1,32'hC,  32'h8C22_0004,  32'hC,  1)); // release buffer
    vecs.push_back(mk(0,1,32'h40,0,0,1,32'hC000_000C, 1,32'h40, 32'h0,     32'hC,  0)); // id redirect flush
    vecs.push_back(mk(0,1,32'h40,1,32'h80,1,32'hC000_0040, 1,32'h80, 32'h0, 32'hC, 0)); // ex wins
    vecs.push_back(mk(0,0,0,0,0,1,32'hC000_0080, 1,32'h84, 32'hC000_0080,  32'h84, 1));
    vecs.push_back(mk(0,1,32'h20,0,0,1,32'hC000_0084, 1,32'h20, 32'h0,     32'h84, 0));
    vecs.push_back(mk(0,0,0,1,32'h100,0,32'h0,   1,32'h20, 32'h0,          32'h84, 0)); // redirect -> DRAIN
    vecs.push_back(mk(0,0,0,0,0,0,32'h0,         1,32'h20, 32'h0,          32'h84, 0));
    vecs.push_back(mk(0,0,0,0,0,1,32'hDEAD_BEEF, 1,32'h100,32'h0,          32'h84, 0)); // drained, discarded
    vecs.push_back(mk(0,0,0,0,0,1,32'hC000_0100, 1,32'h104,32'hC000_0100,  32'h104,1));
    vecs.push_back(mk(0,0,0,1,32'hFFFF_FFFC,1,32'hC000_0104, 1,32'hFFFF_FFFC, 32'h0, 32'h104, 0));
    vecs.push_back(mk(0,0,0,0,0,1,32'h014B_4820, 1,32'h0,  32'h014B_4820,  32'h0,  1)); // pc wraps
    vecs.push_back(mk(1,0,0,0,0,0,32'h0,         1,32'h0,  32'h014B_4820,  32'h0,  1)); // wait+stall holds
    vecs.push_back(mk(0,0,0,0,0,0,32'h0,         1,32'h0,  32'h0,          32'h0,  0)); // wait inserts bubble

    repeat (2) tick();
    chk_state("reset", 0, 32'h0, 32'h0, 32'h0, 0);
    chk("reset.perf_fetched", perf_fetched, 32'h0);
    chk("reset.perf_bubbles", perf_bubbles, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].stall, vecs[i].idr, vecs[i].idt, vecs[i].exr, vecs[i].ext,
            vecs[i].rdy, vecs[i].rdata);
      tick();
      chk_state($sformatf("v%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_instr,
                vecs[i].e_pc4, vecs[i].e_valid);
    end

`ifdef FETCH_PERF_CNT_EN
    chk("table.perf_fetched", perf_fetched, 32'd8);
    chk("table.perf_bubbles", perf_bubbles, 32'd10);
`else
    chk("table.perf_fetched", perf_fetched, 32'd0);
    chk("table.perf_bubbles", perf_bubbles, 32'd0);
`endif

    // Asynchronous reset in the middle of an outstanding request.
    drive(0, 0, 0, 0, 0, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("arst.req",   32'(imem_req),    32'h0);
    chk("arst.valid", 32'(if_id_valid), 32'h0);
    chk("arst.addr",  imem_addr,        32'h0);
    chk("arst.perf_fetched", perf_fetched, 32'h0);
    tick();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 1, 32'h1234_5678);
    tick();
    chk_state("arst.ign", 1, 32'h0, 32'h0, 32'h0, 0);
    drive(0, 0, 0, 0, 0, 1, 32'hC000_0000);
    tick();
    chk_state("arst.ld", 1, 32'h4, 32'hC000_0000, 32'h4, 1);

    // DRAIN: later redirects retarget the pending PC, old address held.
    drive(0, 1, 32'h40, 0, 0, 0, 32'h0);
    tick();
    chk_state("drn.a", 1, 32'h4, 32'h0, 32'h4, 0);
    drive(0, 0, 0, 1, 32'h80, 0, 32'h0);
    tick();
    chk_state("drn.b", 1, 32'h4, 32'h0, 32'h4, 0);
    drive(0, 1, 32'h60, 0, 0, 0, 32'h0);
    tick();
    chk_state("drn.c", 1, 32'h4, 32'h0, 32'h4, 0);
    drive(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    tick();
    chk_state("drn.d", 1, 32'h60, 32'h0, 32'h4, 0);
    drive(0, 0, 0, 0, 0, 1, 32'hC000_0060);
    tick();
    chk_state("drn.e", 1, 32'h64, 32'hC000_0060, 32'h64, 1);

`ifdef FETCH_PERF_CNT_EN
    chk("seq.perf_fetched", perf_fetched, 32'd2);
    chk("seq.perf_bubbles", perf_bubbles, 32'd5);
`else
    chk("seq.perf_fetched", perf_fetched, 32'd0);
    chk("seq.perf_bubbles", perf_bubbles, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS-subset pipeline.
- Owns the PC and runs a variable-latency request/ready handshake to instruction memory.
- Applies stall from the hazard unit and redirects from ID (j, jr) and EX (bltz taken).
- Presents the latched instruction, PC+4 and the op/func fields to the control decoder in ID.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
- NOP_INSTR, 32'h0000_0000, instruction word inserted as a bubble; decodes to all-zero controls.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hazard unit: hold PC and IF/ID.
- id_redirect  in  1  ID resolved j or jr this cycle.
- id_target  in  32  ID redirect target.
- ex_redirect  in  1  EX resolved taken branch this cycle.
- ex_target  in  32  EX redirect target.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address (PC).
- imem_ready  in  1  imem_rdata valid; completes request.
- imem_rdata  in  32  fetched instruction.
- if_id_instr  out  32  latched instruction.
- if_id_pc4  out  32  PC+4 of latched instruction.
- if_id_valid  out  1  latched instruction is real (not bubble).
- op  out  6  if_id_instr[31:26] to control decoder.
- func  out  6  if_id_instr[5:0] to control decoder.
- perf_fetched  out  32  retired-fetch count (optional feature).
- perf_bubbles  out  32  bubble-insert count (optional feature).

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC; if_id_instr=NOP_INSTR, if_id_pc4=0, if_id_valid=0; imem_req=0; state=FETCH; pending target cleared; perf counters 0.
- Redirect select: ex_redirect has priority over id_redirect (older instruction wins). redir = ex_redirect|id_redirect; tgt = ex_redirect ? ex_target : id_target.
- Flush beats stall: any cycle with redir loads IF/ID with NOP_INSTR, valid=0, pc4 unchanged.
- No delay slot: the instruction after j/jr/bltz is always squashed.
- imem_addr = pc in FETCH and DRAIN; imem_addr and imem_req must stay stable while imem_req && !imem_ready.
- PC+4 arithmetic is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- FSM:
  - FETCH: imem_req=1.
    - ready && redir: discard rdata; pc<=tgt; stay FETCH.
    - ready && !redir && stall: rdata->holding buffer; go HELD.
    - ready && !redir && !stall: IF/ID<={rdata, pc+4, 1}; pc<=pc+4; stay FETCH (back-to-back, 1 instr/cycle at zero wait).
    - !ready && redir: pending<=tgt; go DRAIN.
    - !ready && !redir: wait; IF/ID holds if stall, else IF/ID loads bubble (valid=0).
  - DRAIN: imem_req=1, old address held.
    - A further redir overwrites pending (EX priority still applies).
    - On ready: discard rdata; pc<=pending; go FETCH.
  - HELD: imem_req=0.
    - redir: drop buffer; pc<=tgt; go FETCH.
    - !stall: IF/ID<={buffer, pc+4, 1}; pc<=pc+4; go FETCH.
    - stall: hold.
- op/func are combinational slices of if_id_instr; bubbles give op=0, func=0.
- Reset mid-request: imem_req drops immediately (async); any later imem_ready is ignored until the first FETCH request.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - perf_fetched increments on every IF/ID load with valid=1.
  - perf_bubbles increments on every IF/ID load with valid=0, whether flush or wait.
  - Both are 32-bit, wrap, and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- Reset release, imem_ready=1 every cycle, rdata=addr-tagged words -> addrs 0,4,8,12 on consecutive cycles; if_id_pc4=4,8,12,16; valid=1.
- stall=1 for 3 cycles while imem returns 0x8C220004 at pc=8 -> state HELD, imem_req=0, IF/ID unchanged; after stall drops, IF/ID=0x8C220004, pc4=12, op=6'b100011.
- id_redirect=1, id_target=0x40 with ready=1 -> IF/ID valid=0, op=0, func=0; next imem_addr=0x40.
- id_redirect (0x40) and ex_redirect (0x80) in the same cycle -> next imem_addr=0x80.
- ex_redirect to 0x100 while imem_ready=0 at pc=0x20 -> imem_addr stays 0x20 until ready; that rdata is discarded; next request at 0x100.
- pc=32'hFFFF_FFFC fetch completes -> if_id_pc4=0, next imem_addr=0; with FETCH_PERF_CNT_EN, perf_fetched/perf_bubbles match the counted loads.
